// File: rtl/median_iter_ctrl.sv
// Quickselect median iteration controller: issues per-pass control tokens
// and recirculates stage feedback. Optional macro: MEDIAN_ITER_TIMEOUT_EN.
module median_iter_ctrl #(
   parameter int BUFF_SIZE     = 1024,
   parameter int BUFF_SIZE_BIT = 16,
   parameter int MEDIAN_POS    = 512,
   parameter int DEFAULT_PIVOT = 127,
   parameter int MAX_ITER      = 9
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [BUFF_SIZE_BIT-1:0] frame_size,
   output logic [7:0]               tok_pivot,
   output logic [BUFF_SIZE_BIT-1:0] tok_buff_size,
   output logic [BUFF_SIZE_BIT-1:0] tok_median_pos,
   output logic [7:0]               tok_second,
   output logic                     tok_wr,
   input  logic                     tok_full,
   output logic                     px_sel,
   input  logic [7:0]               fb_pivot,
   input  logic [7:0]               fb_second,
   input  logic [BUFF_SIZE_BIT-1:0] fb_buff_size,
   input  logic [BUFF_SIZE_BIT-1:0] fb_median_pos,
   input  logic                     fb_valid,
   output logic                     fb_rd,
   output logic [7:0]               median,
   output logic                     median_valid,
   output logic                     busy,
   output logic [3:0]               iter_count,
   output logic                     err
);

   localparam logic [7:0] PIV0 = 8'(DEFAULT_PIVOT);
   localparam logic [BUFF_SIZE_BIT-1:0] MPOS0 = BUFF_SIZE_BIT'(MEDIAN_POS);
   localparam logic [BUFF_SIZE_BIT-1:0] ONE = BUFF_SIZE_BIT'(1);
`ifdef MEDIAN_ITER_TIMEOUT_EN
   localparam logic [3:0] IT_LAST = 4'(MAX_ITER - 1);
`endif

   logic [31:0] unused_cfg;
   assign unused_cfg = 32'(BUFF_SIZE + MAX_ITER);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [7:0]               piv_q, sec_q, lat_piv, lat_sec;
   logic [BUFF_SIZE_BIT-1:0] bsz_q, mpos_q, lat_bsz, lat_mpos;
   logic                     px_q, err_q;
   logic [3:0]               it_q;
   logic [7:0]               med_q;

   logic ld_start, ld_zero, ld_next, ld_end, set_err;

   assign tok_pivot      = piv_q;
   assign tok_buff_size  = bsz_q;
   assign tok_median_pos = mpos_q;
   assign tok_second     = sec_q;
   assign px_sel         = px_q;
   assign iter_count     = it_q;
   assign median         = med_q;
   assign err            = err_q;
   assign median_valid   = (state_q == S_DONE);
   assign busy           = (state_q != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tok_wr   = 1'b0;
      fb_rd    = 1'b0;
      ld_start = 1'b0;
      ld_zero  = 1'b0;
      ld_next  = 1'b0;
      ld_end   = 1'b0;
      set_err  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (frame_size != '0) begin
                  ld_start = 1'b1;
                  state_d  = S_ISSUE;
               end else begin
                  ld_zero = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            tok_wr = ~tok_full;
            if (!tok_full)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            fb_rd = fb_valid;
            if (fb_valid)
               state_d = S_CHECK;
         end
         S_CHECK: begin
            // A pass that fails to shrink the window would loop forever.
            if (lat_bsz <= ONE) begin
               ld_end  = 1'b1;
               state_d = S_DONE;
            end else if (lat_bsz >= bsz_q) begin
               ld_end  = 1'b1;
               set_err = 1'b1;
               state_d = S_DONE;
            end
`ifdef MEDIAN_ITER_TIMEOUT_EN
            else if (it_q == IT_LAST) begin
               ld_end  = 1'b1;
               set_err = 1'b1;
               state_d = S_DONE;
            end
`endif
            else begin
               ld_next = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         piv_q    <= '0;
         bsz_q    <= '0;
         mpos_q   <= '0;
         sec_q    <= '0;
         lat_piv  <= '0;
         lat_bsz  <= '0;
         lat_mpos <= '0;
         lat_sec  <= '0;
         px_q     <= 1'b0;
         it_q     <= '0;
         med_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (ld_start) begin
            piv_q  <= PIV0;
            bsz_q  <= frame_size;
            mpos_q <= MPOS0;
            sec_q  <= '0;
            px_q   <= 1'b0;
            it_q   <= '0;
            err_q  <= 1'b0;
         end
         if (ld_zero) begin
            med_q <= PIV0;
            err_q <= 1'b1;
         end
         if (fb_rd) begin
            lat_piv  <= fb_pivot;
            lat_bsz  <= fb_buff_size;
            lat_mpos <= fb_median_pos;
            lat_sec  <= fb_second;
         end
         if (ld_end)
            med_q <= lat_piv;
         if (set_err)
            err_q <= 1'b1;
         if (ld_next) begin
            piv_q  <= lat_piv;
            bsz_q  <= lat_bsz;
            mpos_q <= lat_mpos;
            sec_q  <= lat_sec;
            px_q   <= 1'b1;
            if (it_q != 4'hF)
               it_q <= it_q + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_median_iter_ctrl.sv
// Randomized bench for median_iter_ctrl against a pass-level model
// of the quickselect iteration rules.
module tb_median_iter_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] frame_size;
   logic [7:0]  tok_pivot, tok_second;
   logic [15:0] tok_buff_size, tok_median_pos;
   logic        tok_wr, tok_full, px_sel;
   logic [7:0]  fb_pivot, fb_second;
   logic [15:0] fb_buff_size, fb_median_pos;
   logic        fb_valid, fb_rd;
   logic [7:0]  median;
   logic        median_valid, busy, err;
   logic [3:0]  iter_count;

   median_iter_ctrl dut (
      .clock(clock), .reset(reset), .start(start),
      .frame_size(frame_size),
      .tok_pivot(tok_pivot), .tok_buff_size(tok_buff_size),
      .tok_median_pos(tok_median_pos), .tok_second(tok_second),
      .tok_wr(tok_wr), .tok_full(tok_full), .px_sel(px_sel),
      .fb_pivot(fb_pivot), .fb_second(fb_second),
      .fb_buff_size(fb_buff_size), .fb_median_pos(fb_median_pos),
      .fb_valid(fb_valid), .fb_rd(fb_rd),
      .median(median), .median_valid(median_valid),
      .busy(busy), .iter_count(iter_count), .err(err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  pv;
      logic [15:0] bs;
      logic [15:0] mp;
      logic [7:0]  sc;
      logic        px;
   } tok_t;

   int nchk = 0;
   int nerr = 0;

   tok_t resp[$];
   tok_t exp_iss[$];
   logic [7:0] exp_med;
   logic       exp_err;
   int         exp_it;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pass-level model: each pass either converges, stalls, times out
   // or narrows the window and feeds its tokens into the next pass.
   task automatic model(input logic [15:0] fs);
      tok_t cur;
      int   it;
      exp_iss.delete();
      exp_err = 1'b0;
      exp_med = 8'd0;
      if (fs == 0) begin
         exp_med = 8'd127;
         exp_err = 1'b1;
         exp_it  = -1;
         return;
      end
      cur = '{pv: 8'd127, bs: fs, mp: 16'd512, sc: 8'd0, px: 1'b0};
      it = 0;
      exp_iss.push_back(cur);
      foreach (resp[k]) begin
         if (resp[k].bs <= 1) begin
            exp_med = resp[k].pv;
            break;
         end
         if (resp[k].bs >= cur.bs) begin
            exp_med = resp[k].pv;
            exp_err = 1'b1;
            break;
         end
`ifdef MEDIAN_ITER_TIMEOUT_EN
         if (it == 8) begin
            exp_med = resp[k].pv;
            exp_err = 1'b1;
            break;
         end
`endif
         cur = resp[k];
         cur.px = 1'b1;
         it = (it < 15) ? it + 1 : 15;
         exp_iss.push_back(cur);
      end
      exp_it = it;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_pv"}, tok_pivot, 0);
      chk({tag, "_bs"}, tok_buff_size, 0);
      chk({tag, "_mp"}, tok_median_pos, 0);
      chk({tag, "_sc"}, tok_second, 0);
      chk({tag, "_wr"}, tok_wr, 0);
      chk({tag, "_rd"}, fb_rd, 0);
      chk({tag, "_px"}, px_sel, 0);
      chk({tag, "_med"}, median, 0);
      chk({tag, "_mv"}, median_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_it"}, iter_count, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   task automatic run_job(input logic [15:0] fs, input bit stall5,
                          input int full_pct);
      int  issued = 0;
      int  ridx = 0;
      bit  pend = 0;
      bit  done = 0;
      tok_t e;
      model(fs);
      @(negedge clock);
      start = 1'b1;
      frame_size = fs;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clock);
         start = 1'b0;
         frame_size = 16'($urandom);
         if (stall5)
            tok_full = (c < 5);
         else
            tok_full = ($urandom_range(99) < full_pct);
         fb_valid = pend && ridx < resp.size() && ($urandom_range(1) == 1);
         if (ridx < resp.size()) begin
            fb_pivot      = resp[ridx].pv;
            fb_buff_size  = resp[ridx].bs;
            fb_median_pos = resp[ridx].mp;
            fb_second     = resp[ridx].sc;
         end
         #1;
         if (stall5 && c < 5) begin
            chk("stall_wr", tok_wr, 0);
            chk("stall_pv", tok_pivot, 127);
            chk("stall_bs", tok_buff_size, fs);
         end
         if (stall5 && c == 5)
            chk("stall_release", tok_wr, 1);
         chk("fb_rd", fb_rd, fb_valid);
         if (tok_wr) begin
            if (issued < exp_iss.size()) begin
               e = exp_iss[issued];
               chk("tok_pv", tok_pivot, e.pv);
               chk("tok_bs", tok_buff_size, e.bs);
               chk("tok_mp", tok_median_pos, e.mp);
               chk("tok_sc", tok_second, e.sc);
               chk("px_sel", px_sel, e.px);
            end else
               chk("extra_wr", 1, 0);
            issued++;
            pend = 1;
         end
         if (fb_rd && pend) begin
            ridx++;
            pend = 0;
         end
         if (median_valid) begin
            done = 1;
            if (fs == 0)
               chk("zero_lat", c, 0);
            chk("median", median, exp_med);
            chk("err", err, exp_err);
            chk("issues", issued, exp_iss.size());
            chk("busy_dn", busy, 1);
            if (exp_it >= 0)
               chk("iter", iter_count, exp_it);
         end
      end
      if (!done)
         chk("job_timeout", 0, 1);
      else begin
         @(negedge clock);
         tok_full = 1'b0;
         fb_valid = 1'b0;
         #1;
         chk("mv_pulse", median_valid, 0);
         chk("busy_after", busy, 0);
         chk("med_hold", median, exp_med);
      end
   endtask

   function automatic tok_t rnd_tok(input logic [15:0] bs);
      tok_t t;
      t.pv = 8'($urandom);
      t.bs = bs;
      t.mp = 16'($urandom_range(1023));
      t.sc = 8'($urandom);
      t.px = 1'b1;
      return t;
   endfunction

   task automatic gen_random(input logic [15:0] fs);
      int last = fs;
      int r, bs;
      resp.delete();
      for (int i = 0; i < 20; i++) begin
         r = $urandom_range(9);
         if (i == 19 || r == 0 || last <= 2)
            bs = $urandom_range(1);
         else if (r == 1)
            bs = last + $urandom_range(3);
         else
            bs = $urandom_range(last - 1, 2);
         resp.push_back(rnd_tok(16'(bs)));
         if (bs < last)
            last = bs;
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      start = 1'b0;
      frame_size = '0;
      tok_full = 1'b0;
      fb_valid = 1'b0;
      fb_pivot = '0;
      fb_second = '0;
      fb_buff_size = '0;
      fb_median_pos = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      #1;
      check_idle_outputs("rst");
      reset = 1'b0;

      resp.delete();
      resp.push_back(rnd_tok(16'd300));
      resp.push_back(rnd_tok(16'd40));
      resp.push_back(rnd_tok(16'd1));
      resp[2].pv = 8'd88;
      run_job(16'd1024, 0, 0);
      chk("nom_med", median, 88);
      chk("nom_it", iter_count, 2);
      chk("nom_err", err, 0);

      run_job(16'd1024, 1, 0);

      resp.delete();
      run_job(16'd0, 0, 0);
      chk("zero_med", median, 127);
      chk("zero_err", err, 1);

      resp.delete();
      resp.push_back(rnd_tok(16'd1024));
      run_job(16'd1024, 0, 30);
      chk("nop_err", err, 1);
      chk("nop_med", median, resp[0].pv);

      resp.delete();
      for (int k = 19; k >= 1; k--)
         resp.push_back(rnd_tok(16'(k)));
      run_job(16'd20, 0, 20);
`ifdef MEDIAN_ITER_TIMEOUT_EN
      chk("tmo_err", err, 1);
`else
      chk("tmo_err", err, 0);
      chk("tmo_sat", iter_count, 15);
`endif

      @(negedge clock);
      start = 1'b1;
      frame_size = 16'd500;
      tok_full = 1'b0;
      fb_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         start = 1'b0;
         #1;
         n++;
      end while (!tok_wr && n < 10);
      chk("rw_wr", tok_wr, 1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("rw_busy", busy, 1);
      @(negedge clock);
      #1;
      check_idle_outputs("rw");
      reset = 1'b0;
      gen_random(16'd700);
      run_job(16'd700, 0, 25);

      for (int j = 0; j < 40; j++) begin
         logic [15:0] fs;
         fs = 16'($urandom_range(1024, 2));
         if ($urandom_range(15) == 0)
            fs = 16'd0;
         gen_random(fs);
         run_job(fs, 0, $urandom_range(60));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/median_iter_ctrl.md
# median_iter_ctrl

Iteration controller for the quickselect median stage (`fill_and_check`). For each window it issues the per-iteration control tokens (pivot, buff_size, median_pos, second_median_value) and selects the pixel source: the external frame on iteration 0, then the stage's own output stream. It consumes the stage's output tokens and either recirculates for another iteration or reports the median.

## Interface
- `BUFF_SIZE`, 1024: maximum window size in pixels.
- `BUFF_SIZE_BIT`, 16: width of size and position fields.
- `MEDIAN_POS`, 512: initial median position issued on iteration 0.
- `DEFAULT_PIVOT`, 127: initial pivot issued on iteration 0.
- `MAX_ITER`, 9: iteration bound; used only with `MEDIAN_ITER_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a median computation; sampled only in IDLE.
- `frame_size` in BUFF_SIZE_BIT: window pixel count; sampled with `start`.
- `tok_pivot` out 8: control token to the stage.
- `tok_buff_size` out BUFF_SIZE_BIT: control token to the stage.
- `tok_median_pos` out BUFF_SIZE_BIT: control token to the stage.
- `tok_second` out 8: control token to the stage.
- `tok_wr` out 1: writes all four token FIFOs together.
- `tok_full` in 1: OR of the four token FIFO full flags.
- `px_sel` out 1: pixel source, 0 = external frame, 1 = stage feedback.
- `fb_pivot`, `fb_second` in 8: stage output tokens.
- `fb_buff_size`, `fb_median_pos` in BUFF_SIZE_BIT: stage output tokens.
- `fb_valid` in 1: all four feedback FIFOs are non-empty.
- `fb_rd` out 1: pops all four feedback FIFOs.
- `median` out 8: result.
- `median_valid` out 1: one-cycle pulse when `median` is valid.
- `busy` out 1: high in every state except IDLE.
- `iter_count` out 4: current iteration index.
- `err` out 1: sticky error, cleared on the next accepted `start`.

## Operation
- **States:** IDLE, ISSUE, WAIT, CHECK, DONE.
- **IDLE:**
  - `start` with `frame_size != 0` loads the token registers: pivot = DEFAULT_PIVOT, buff_size = frame_size, median_pos = MEDIAN_POS, second = 0.
  - Same event sets `px_sel` = 0 and `iter_count` = 0, clears `err`, and goes to ISSUE.
  - `start` with `frame_size == 0` sets `median` = DEFAULT_PIVOT and `err` = 1, and goes to DONE.
  - `start` outside IDLE is ignored.
- **ISSUE:**
  - `tok_wr` = ~`tok_full` (combinational).
  - On a write, go to WAIT.
  - Token outputs hold stable while `tok_full` is high.
- **WAIT:**
  - `fb_rd` = `fb_valid` (combinational).
  - When `fb_rd` is high, latch all four fb_* values and go to CHECK.
- **CHECK:**
  - If latched buff_size ≤ 1: `median` = latched pivot, go to DONE.
  - Else if latched buff_size ≥ the buff_size last issued (no progress): `err` = 1, `median` = latched pivot, go to DONE.
  - Else: token registers take the latched fb values, `iter_count` +1, `px_sel` = 1, go to ISSUE.
- **DONE:** `median_valid` = 1 for exactly one cycle, then go to IDLE.
- **Widths:** `iter_count` saturates at 15. buff_size comparisons are unsigned over BUFF_SIZE_BIT.
- **Reset values:** state IDLE; all token outputs 0; `tok_wr` 0; `fb_rd` 0; `px_sel` 0; `median` 0; `median_valid` 0; `busy` 0; `iter_count` 0; `err` 0.
- **Reset mid-operation:** returns to IDLE in one cycle and flushes nothing. The stage and its FIFOs are reset by the same `reset`.
- **Simultaneous `tok_full` and `fb_valid`:** cannot conflict; only one of ISSUE or WAIT is active at a time.

## Timing
- `start` accepted at cycle N: `tok_wr` can assert at N+1.
- Stalls: each cycle of `tok_full` delays the write by one cycle.
- `fb_rd` asserts in the same cycle `fb_valid` is seen in WAIT (cycle M).
- CHECK occurs at M+1.
- Next outcome at M+2: either `tok_wr` (next iteration, earliest) or the `median_valid` pulse.
- `median` holds its value until the next DONE or reset.
- `busy` is low in the cycle after the `median_valid` pulse.

## Configuration
- **`MEDIAN_ITER_TIMEOUT_EN` defined:** in CHECK, if the stage has not converged and `iter_count` == MAX_ITER-1, set `err` = 1, `median` = latched pivot, and go to DONE.
- **Not defined:**
  - No iteration bound; only the no-progress check terminates on error.
  - `MAX_ITER` is unused.

## Test plan
- **Nominal convergence:** reset, then `start` with `frame_size` = 1024; feedback returns buff_size 300, then 40, then 1 with pivot 88 → three `tok_wr` pulses; `px_sel` 0, then 1, then 1; `median` = 88 with a single `median_valid`; `iter_count` = 2; `err` = 0.
- **Backpressure:** hold `tok_full` for 5 cycles in ISSUE → `tok_wr` low throughout and tokens stable; write occurs in the cycle `tok_full` drops.
- **Zero frame:** `start` with `frame_size` = 0 → `median_valid` at N+1, `median` = 127, `err` = 1, no `tok_wr`.
- **No progress:** feedback buff_size 1024 after issuing 1024 → `err` = 1, `median` = fb_pivot.
- **Timeout:** with `MEDIAN_ITER_TIMEOUT_EN`, feedback buff_size decrements by 1 each iteration → DONE after exactly 9 issues, `err` = 1. Without the macro, iteration continues to convergence.
- **Reset mid-WAIT:** assert `reset` in WAIT → next cycle IDLE and all outputs at reset values; a later `start` runs normally.
